data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory behind a valid/ready request/response handshake.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        acc_we;
  logic [1:0]  acc_size;
  logic        acc_signed;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        access;
  logic        fault;
  logic        mem_wr;
  logic [AW-1:0] idx;
  logic [31:0] cur_word;

  // Storage holds the XOR of the live word with its power-up image, so
  // zero-initialised cells read back as the required power-up contents.
  logic [31:0] mem_q [DEPTH];

  function automatic logic [31:0] init_word(input logic [AW-1:0] i);
    logic [31:0] iw;
    iw = 32'(i);
    return (iw <= 32'd10) ? (32'd10 - iw) : 32'd0;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    logic [31:0] w;
    w = old_w;
    case (sz)
      2'b00:   w[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   w[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic        sgn,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // With WAIT_CYC=0 the access happens on the accept edge, so use live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we     = req_we;
      acc_size   = req_size;
      acc_signed = req_signed;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = we_q;
      acc_size   = size_q;
      acc_signed = signed_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  assign idx      = acc_addr[AW+1:2];
  assign cur_word = mem_q[idx] ^ init_word(idx);

  always_comb begin
    fault = (acc_addr[31:AW+2] != '0);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (acc_size == 2'b01) begin
      fault = fault | acc_addr[0];
    end else if (acc_size[1]) begin
      fault = fault | (acc_addr[1:0] != 2'b00);
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    access   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_wr = access & acc_we & ~fault;
    if (access) begin
      err_d   = fault;
      rdata_d = (fault | acc_we) ? 32'h0
                                 : extract_load(cur_word, acc_size, acc_signed, acc_addr[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q     <= we_d;
    size_q   <= size_d;
    signed_q <= signed_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[idx] <= merge_lanes(cur_word, acc_wdata, acc_size, acc_addr[1:0]) ^ init_word(idx);
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with DEPTH=64, WAIT_CYC=2.
module tb_data_mem_ctrl;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          n_checks;
  int          n_errors;
  logic [31:0] got_rdata;
  logic        got_err;

  data_mem_ctrl #(.DEPTH(64), .WAIT_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request, take the accept edge, then wait (bounded) for rsp_valid.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    int lat;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'd2);
  endtask

  task automatic complete();
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wd);
    issue(we, sz, sgn, addr, wd);
    complete();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);

    txn(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    chk("ld_w_00", got_rdata, 32'h0000000A);
    chk("ld_w_00_err", {31'h0, got_err}, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    chk("ld_w_04", got_rdata, 32'h00000009);
    txn(1'b0, 2'b10, 1'b0, 32'h28, 32'h0);
    chk("ld_w_28", got_rdata, 32'h00000000);

    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("st_w_10_rdata", got_rdata, 32'h0);
    chk("st_w_10_err", {31'h0, got_err}, 32'h0);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("ld_bs_13", got_rdata, 32'hFFFFFFDE);
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("ld_bu_13", got_rdata, 32'h000000DE);
    txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("ld_hs_10", got_rdata, 32'hFFFFBEEF);

    txn(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("ld_w_10_after_byte", got_rdata, 32'hDEAD55EF);
    txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("ld_hu_10", got_rdata, 32'h000055EF);
    txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("ld_hu_12", got_rdata, 32'h0000DEAD);

    txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
    chk("st_oor_err", {31'h0, got_err}, 32'h1);
    chk("st_oor_rdata", got_rdata, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    chk("ld_w_00_after_oor", got_rdata, 32'h0000000A);
    txn(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    chk("ld_w_fc_err", {31'h0, got_err}, 32'h0);

    txn(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("ld_w_12_err", {31'h0, got_err}, 32'h1);
    chk("ld_w_12_rdata", got_rdata, 32'h0);
`else
    chk("ld_w_12_err", {31'h0, got_err}, 32'h0);
    chk("ld_w_12_rdata", got_rdata, 32'hDEAD55EF);
`endif

    // Response back-pressure: outputs must hold while rsp_ready stays low.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hDEAD55EF);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
    end
    complete();
    chk("stall_final_rdata", got_rdata, 32'hDEAD55EF);

    // Reset in WAIT (one edge before the write would commit) drops the store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_wait_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_wait_rsp_valid2", {31'h0, rsp_valid}, 32'h0);
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    // word 8 keeps its power-up value 10-8
    chk("ld_w_20_after_drop", got_rdata, 32'h00000002);

    // Reset in RESP: the store has already committed and must survive.
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_resp_rsp_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    chk("ld_w_24_after_rst", got_rdata, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
